// File: rtl/xadc_drp_pkg.sv
// Shared constants and types for the XADC DRP responder stand-in.
package xadc_drp_pkg;

    // DRP register addresses
    localparam logic [6:0] ADDR_AUX3  = 7'h13;
    localparam logic [6:0] ADDR_AUX11 = 7'h1B;
    localparam logic [6:0] ADDR_CFG0  = 7'h40;
    localparam logic [6:0] ADDR_CFG1  = 7'h41;
    localparam logic [6:0] ADDR_CFG2  = 7'h42;

    // Channel numbers reported on the channel output
    localparam logic [4:0] CH_AUX3  = 5'd3;
    localparam logic [4:0] CH_AUX11 = 5'd11;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} drp_state_e;

    // Status registers hold the 12-bit result left-justified in 16 bits
    function automatic logic [15:0] left_justify(input logic [11:0] s);
        return {s, 4'b0000};
    endfunction

endpackage

// File: rtl/xadc_conv_sequencer.sv
// Free-running two-channel conversion sequencer (aux 3, aux 11).
// Emits eoc/channel/busy and a one-cycle status-register write strobe that
// is asserted during the eoc cycle, so the register lands on the next edge.
// Optional macro XADC_RAMP_GEN_EN replaces the sample inputs with an
// internal ramp (ch3 = counter, ch11 = ~counter).
module xadc_conv_sequencer
    import xadc_drp_pkg::*;
#(
    parameter int CONV_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] sample_a,
    input  logic [11:0] sample_b,
    output logic        eoc,
    output logic [4:0]  channel,
    output logic        busy,
    output logic        st_we,
    output logic [6:0]  st_addr,
    output logic [15:0] st_data
);
    localparam int CW = $clog2(CONV_CYCLES);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          wrap;
    logic          sel_b;      // 0: next conversion is aux3, 1: aux11
    logic [11:0]   src_a;
    logic [11:0]   src_b;

    assign wrap    = (cnt == CW'(CONV_CYCLES - 1));
    assign cnt_nxt = wrap ? '0 : cnt + 1'b1;

`ifdef XADC_RAMP_GEN_EN
    logic [11:0] ramp;
    wire         unused_samples = ^{sample_a, sample_b};

    // Ramp advances once per aux3/aux11 pair so both channels of a pair
    // see the same counter value (ch11 gets its inverse).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ramp <= '0;
        else if (wrap && sel_b)
            ramp <= ramp + 1'b1;
    end

    assign src_a = ramp;
    assign src_b = ~ramp;
`else
    assign src_a = sample_a;
    assign src_b = sample_b;
`endif

    // Conversion counter, channel toggle and registered sequencer outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            sel_b   <= 1'b0;
            eoc     <= 1'b0;
            channel <= '0;
            busy    <= 1'b0;
            st_we   <= 1'b0;
            st_addr <= '0;
            st_data <= '0;
        end else begin
            cnt   <= cnt_nxt;
            busy  <= (cnt_nxt >= CW'(CONV_CYCLES - 4));
            eoc   <= wrap;
            st_we <= wrap;
            if (wrap) begin
                channel <= sel_b ? CH_AUX11 : CH_AUX3;
                st_addr <= sel_b ? ADDR_AUX11 : ADDR_AUX3;
                st_data <= left_justify(sel_b ? src_b : src_a);
                sel_b   <= ~sel_b;
            end
        end
    end

endmodule

// File: rtl/xadc_drp_responder.sv
// DRP responder end of an XADC stand-in: register file plus DRP FSM.
// Reads are snapshotted on the den cycle and returned DRP_LATENCY cycles
// later; writes commit on the drdy cycle. Optional ramp source is selected
// inside the sequencer by macro XADC_RAMP_GEN_EN.
module xadc_drp_responder
    import xadc_drp_pkg::*;
#(
    parameter int CONV_CYCLES = 256,
    parameter int DRP_LATENCY = 4,
    parameter int ADDR_W      = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] daddr,
    input  logic              den,
    input  logic              dwe,
    input  logic [15:0]       di,
    output logic [15:0]       do_out,
    output logic              drdy,
    output logic              eoc,
    output logic [4:0]        channel,
    output logic              busy,
    input  logic [11:0]       sample_a,
    input  logic [11:0]       sample_b,
    output logic              drp_err
);
    logic              st_we;
    logic [6:0]        st_addr;
    logic [15:0]       st_data;
    logic [15:0]       st_aux3, st_aux11;
    logic [15:0]       cfg0, cfg1, cfg2;
    logic [15:0]       rd_val;
    logic [15:0]       snap;
    drp_state_e        state;
    logic [3:0]        lat;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [15:0]       req_data;

    xadc_conv_sequencer #(.CONV_CYCLES(CONV_CYCLES)) u_seq (
        .clk      (clk),
        .rst_n    (rst_n),
        .sample_a (sample_a),
        .sample_b (sample_b),
        .eoc      (eoc),
        .channel  (channel),
        .busy     (busy),
        .st_we    (st_we),
        .st_addr  (st_addr),
        .st_data  (st_data)
    );

    // Status registers, written only by the sequencer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_aux3  <= '0;
            st_aux11 <= '0;
        end else if (st_we) begin
            if (st_addr == ADDR_AUX3)  st_aux3  <= st_data;
            if (st_addr == ADDR_AUX11) st_aux11 <= st_data;
        end
    end

    // Read decode of the live register file at the requested address
    always_comb begin
        rd_val = '0;
        case (daddr)
            ADDR_W'(ADDR_AUX3):  rd_val = st_aux3;
            ADDR_W'(ADDR_AUX11): rd_val = st_aux11;
            ADDR_W'(ADDR_CFG0):  rd_val = cfg0;
            ADDR_W'(ADDR_CFG1):  rd_val = cfg1;
            ADDR_W'(ADDR_CFG2):  rd_val = cfg2;
            default:             rd_val = '0;
        endcase
    end

    // DRP FSM: capture on den, count latency, pulse drdy, commit writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            lat      <= '0;
            req_we   <= 1'b0;
            req_addr <= '0;
            req_data <= '0;
            snap     <= '0;
            drdy     <= 1'b0;
            do_out   <= '0;
            drp_err  <= 1'b0;
            cfg0     <= '0;
            cfg1     <= '0;
            cfg2     <= '0;
        end else begin
            drdy   <= 1'b0;
            do_out <= '0;
            // A strobe while busy is dropped but remembered until reset
            if (den && state != IDLE)
                drp_err <= 1'b1;
            case (state)
                IDLE: if (den) begin
                    req_we   <= dwe;
                    req_addr <= daddr;
                    req_data <= di;
                    snap     <= rd_val;
                    if (DRP_LATENCY == 1) begin
                        state  <= RESP;
                        drdy   <= 1'b1;
                        do_out <= dwe ? 16'h0000 : rd_val;
                    end else begin
                        state <= WAIT;
                        lat   <= 4'(DRP_LATENCY - 1);
                    end
                end
                // Last count is consumed by the transition so drdy lands
                // exactly DRP_LATENCY cycles after the den cycle
                WAIT: if (lat == 4'd1) begin
                    state  <= RESP;
                    drdy   <= 1'b1;
                    do_out <= req_we ? 16'h0000 : snap;
                end else begin
                    lat <= lat - 1'b1;
                end
                RESP: begin
                    state <= IDLE;
                    if (req_we) begin
                        if (req_addr == ADDR_W'(ADDR_CFG0)) cfg0 <= req_data;
                        if (req_addr == ADDR_W'(ADDR_CFG1)) cfg1 <= req_data;
                        if (req_addr == ADDR_W'(ADDR_CFG2)) cfg2 <= req_data;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xadc_drp_responder.sv
// Randomized self-checking bench for xadc_drp_responder.
// Reference model: conversion k completes at cycle k*CONV after reset
// release, odd k is aux3, even k is aux11; results become readable one
// cycle after eoc. Config registers are modelled as a plain array.
module tb_xadc_drp_responder;
    localparam int CONV = 256;
    localparam int LAT  = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  daddr;
    logic        den, dwe;
    logic [15:0] di;
    logic [15:0] do_out;
    logic        drdy, eoc, busy, drp_err;
    logic [4:0]  channel;
    logic [11:0] sample_a, sample_b;

    int n_chk  = 0;
    int n_pass = 0;
    bit mon_en = 1'b0;

    xadc_drp_responder #(.CONV_CYCLES(CONV), .DRP_LATENCY(LAT), .ADDR_W(7)) dut (
        .clk(clk), .rst_n(rst_n), .daddr(daddr), .den(den), .dwe(dwe), .di(di),
        .do_out(do_out), .drdy(drdy), .eoc(eoc), .channel(channel), .busy(busy),
        .sample_a(sample_a), .sample_b(sample_b), .drp_err(drp_err)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int          cyc;
    logic [15:0] m_st3, m_st11;
    logic [15:0] m_cfg [3];
    bit          pend_v;
    int          pend_ch;
    logic [15:0] pend_val;

    function automatic logic [11:0] conv_sample(input int k);
`ifdef XADC_RAMP_GEN_EN
        logic [11:0] r;
        r = 12'((k - 1) / 2);
        return (k % 2 == 1) ? r : ~r;
`else
        return (k % 2 == 1) ? sample_a : sample_b;
`endif
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc = 0; m_st3 = 0; m_st11 = 0; pend_v = 0;
        end else begin
            if (pend_v) begin
                if (pend_ch == 3) m_st3 = pend_val; else m_st11 = pend_val;
                pend_v = 0;
            end
            cyc++;
            if (cyc % CONV == 0) begin
                pend_v   = 1;
                pend_ch  = ((cyc / CONV) % 2 == 1) ? 3 : 11;
                pend_val = {conv_sample(cyc / CONV), 4'b0000};
            end
        end
    end

    function automatic logic [15:0] model_read(input logic [6:0] a);
        case (a)
            7'h13:   return m_st3;
            7'h1B:   return m_st11;
            7'h40:   return m_cfg[0];
            7'h41:   return m_cfg[1];
            7'h42:   return m_cfg[2];
            default: return 16'h0000;
        endcase
    endfunction

    // Sequencer outputs checked every cycle against the conversion schedule
    always @(negedge clk) begin
        if (mon_en) begin
            logic       e_eoc, e_busy;
            logic [4:0] e_ch;
            int         k;
            k      = cyc / CONV;
            e_eoc  = (cyc > 0) && (cyc % CONV == 0);
            e_busy = (cyc % CONV) >= CONV - 4;
            e_ch   = (k == 0) ? 5'd0 : ((k % 2 == 1) ? 5'd3 : 5'd11);
            n_chk++;
            if (eoc !== e_eoc) $display("FAIL eoc cyc=%0d got=%b exp=%b", cyc, eoc, e_eoc);
            else n_pass++;
            n_chk++;
            if (busy !== e_busy) $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, e_busy);
            else n_pass++;
            n_chk++;
            if (channel !== e_ch) $display("FAIL channel cyc=%0d got=%0d exp=%0d", cyc, channel, e_ch);
            else n_pass++;
        end
    end

    // Drive one DRP transaction; returns latency, data seen on drdy and the
    // model's expected read value at the den cycle. now=1 drives in the
    // current cycle instead of waiting for the next edge.
    task automatic drp_xact(input logic [6:0] a, input logic we, input logic [15:0] d,
                            input bit now, output int lat, output logic [15:0] dout,
                            output logic [15:0] exp);
        if (!now) begin @(posedge clk); #1; end
        daddr = a; dwe = we; di = d; den = 1'b1;
        exp = model_read(a);
        lat = 0; dout = 16'hxxxx;
        while (lat < 20) begin
            @(posedge clk); #1 den = 1'b0; dwe = 1'b0;
            lat++;
            @(negedge clk);
            if (drdy === 1'b1) break;
        end
        if (drdy === 1'b1) begin
            dout = do_out;
            if (we && a >= 7'h40 && a <= 7'h42) m_cfg[a - 7'h40] = d;
        end
    endtask

    task automatic wait_cyc(input int t);
        int guard = 0;
        while (cyc < t && guard < 4 * CONV) begin @(posedge clk); #1; guard++; end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        int lat; logic [15:0] dout, exp;
        rst_n = 1'b0; den = 0; dwe = 0; daddr = 0; di = 0;
        for (int i = 0; i < 3; i++) m_cfg[i] = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_chk++;
        if ({do_out, drdy, eoc, channel, busy, drp_err} !== '0)
            $display("FAIL reset_outputs got=%h/%b/%b/%0d/%b/%b exp=all zero",
                     do_out, drdy, eoc, channel, busy, drp_err);
        else n_pass++;
        @(posedge clk); #1 rst_n = 1'b1; mon_en = 1'b1;
        drp_xact(7'h13, 1'b0, 16'h0, 1'b0, lat, dout, exp);
        n_chk++;
        if (lat != LAT || dout !== 16'h0000)
            $display("FAIL reset_status_read lat=%0d got=%h exp lat=%0d val=0000", lat, dout, LAT);
        else n_pass++;
    endtask

    task automatic test_conversion();
        int lat; logic [15:0] dout, exp;
        logic [11:0] sa, sb;
        sa = 12'($urandom); sb = 12'($urandom);
        sample_a = sa; sample_b = sb;
        wait_cyc(CONV + 3);
        drp_xact(7'h13, 1'b0, 16'h0, 1'b0, lat, dout, exp);
        n_chk++;
`ifdef XADC_RAMP_GEN_EN
        if (lat != LAT || dout !== 16'h0000)
            $display("FAIL conv_aux3 lat=%0d got=%h exp=0000", lat, dout);
`else
        if (lat != LAT || dout !== {sa, 4'b0})
            $display("FAIL conv_aux3 lat=%0d got=%h exp=%h", lat, dout, {sa, 4'b0});
`endif
        else n_pass++;
        wait_cyc(2 * CONV + 3);
        drp_xact(7'h1B, 1'b0, 16'h0, 1'b0, lat, dout, exp);
        n_chk++;
`ifdef XADC_RAMP_GEN_EN
        if (lat != LAT || dout !== 16'hFFF0)
            $display("FAIL conv_aux11 lat=%0d got=%h exp=fff0", lat, dout);
`else
        if (lat != LAT || dout !== {sb, 4'b0})
            $display("FAIL conv_aux11 lat=%0d got=%h exp=%h", lat, dout, {sb, 4'b0});
`endif
        else n_pass++;
    endtask

    task automatic test_cfg_rw();
        int lat; logic [15:0] dout, exp, wv;
        wv = 16'($urandom);
        drp_xact(7'h41, 1'b1, wv, 1'b0, lat, dout, exp);
        n_chk++;
        if (lat != LAT || dout !== 16'h0000)
            $display("FAIL cfg_write_resp lat=%0d got=%h exp=0000", lat, dout);
        else n_pass++;
        drp_xact(7'h41, 1'b0, 16'h0, 1'b0, lat, dout, exp);
        n_chk++;
        if (lat != LAT || dout !== wv)
            $display("FAIL cfg_readback lat=%0d got=%h exp=%h", lat, dout, wv);
        else n_pass++;
        drp_xact(7'h13, 1'b1, 16'hFFFF, 1'b0, lat, dout, exp);
        drp_xact(7'h13, 1'b0, 16'h0, 1'b0, lat, dout, exp);
        n_chk++;
        if (lat != LAT || dout !== exp || dout === 16'hFFFF)
            $display("FAIL status_ro got=%h exp=%h", dout, exp);
        else n_pass++;
        n_chk++;
        if (drp_err !== 1'b0) $display("FAIL err_clean got=%b exp=0", drp_err);
        else n_pass++;
    endtask

    task automatic test_random();
        int lat; logic [15:0] dout, exp, d;
        logic [6:0] a; logic we;
        logic [6:0] addrs [6];
        addrs = '{7'h13, 7'h1B, 7'h40, 7'h41, 7'h42, 7'h00};
        for (int i = 0; i < 12; i++) begin
            a  = addrs[$urandom_range(0, 5)];
            if (a == 7'h00) a = 7'($urandom);
            we = 1'($urandom);
            d  = 16'($urandom);
            drp_xact(a, we, d, 1'b0, lat, dout, exp);
            n_chk++;
            if (lat != LAT || dout !== (we ? 16'h0000 : exp))
                $display("FAIL rand_xact addr=%h we=%b lat=%0d got=%h exp=%h",
                         a, we, lat, dout, we ? 16'h0000 : exp);
            else n_pass++;
        end
    endtask

    task automatic test_eoc_collision();
        int lat, guard; logic [15:0] dout, exp, old_v;
        logic [11:0] ns;
        // New aux3 sample must differ from what is in the register now
        old_v = m_st3;
        ns = 12'($urandom);
        if ({ns, 4'b0} == old_v) ns = ns + 12'd1;
        sample_a = ns;
        guard = 0;
        // Park on the cycle where an aux3 eoc is high
        while (!(cyc > 0 && cyc % CONV == 0 && (cyc / CONV) % 2 == 1) && guard < 3 * CONV) begin
            @(posedge clk); #1; guard++;
        end
        drp_xact(7'h13, 1'b0, 16'h0, 1'b1, lat, dout, exp);
        n_chk++;
        if (lat != LAT || dout !== old_v)
            $display("FAIL eoc_den_old lat=%0d got=%h exp=%h", lat, dout, old_v);
        else n_pass++;
        drp_xact(7'h13, 1'b0, 16'h0, 1'b0, lat, dout, exp);
        n_chk++;
`ifdef XADC_RAMP_GEN_EN
        if (lat != LAT || dout !== exp)
            $display("FAIL eoc_den_new lat=%0d got=%h exp=%h", lat, dout, exp);
`else
        if (lat != LAT || dout !== {ns, 4'b0})
            $display("FAIL eoc_den_new lat=%0d got=%h exp=%h", lat, dout, {ns, 4'b0});
`endif
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int pulses, first, lat; logic [15:0] got, exp1, dout, exp;
        @(posedge clk); #1;
        daddr = 7'h41; dwe = 1'b0; den = 1'b1;
        exp1 = model_read(7'h41);
        pulses = 0; first = 0; got = 16'h0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            den = (i == 2); dwe = (i == 2); daddr = 7'h40; di = 16'($urandom);
            @(negedge clk);
            if (drdy === 1'b1) begin
                pulses++;
                if (first == 0) begin first = i; got = do_out; end
            end
        end
        den = 1'b0; dwe = 1'b0;
        n_chk++;
        if (pulses != 1 || first != LAT || got !== exp1)
            $display("FAIL b2b_single_drdy pulses=%0d lat=%0d got=%h exp pulses=1 lat=%0d val=%h",
                     pulses, first, got, LAT, exp1);
        else n_pass++;
        n_chk++;
        if (drp_err !== 1'b1) $display("FAIL b2b_err_set got=%b exp=1", drp_err);
        else n_pass++;
        drp_xact(7'h40, 1'b0, 16'h0, 1'b0, lat, dout, exp);
        n_chk++;
        if (lat != LAT || dout !== exp)
            $display("FAIL b2b_ignored_write got=%h exp=%h", dout, exp);
        else n_pass++;
        n_chk++;
        if (drp_err !== 1'b1) $display("FAIL b2b_err_sticky got=%b exp=1", drp_err);
        else n_pass++;
    endtask

    task automatic test_reset_mid_write();
        int pulses, lat; logic [15:0] dout, exp;
        @(posedge clk); #1;
        daddr = 7'h40; dwe = 1'b1; di = 16'($urandom) | 16'h0001; den = 1'b1;
        @(posedge clk); #1 den = 1'b0; dwe = 1'b0;
        @(posedge clk); #1 rst_n = 1'b0;
        for (int i = 0; i < 3; i++) m_cfg[i] = 0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (drdy !== 1'b0) pulses++;
        end
        n_chk++;
        if (pulses != 0) $display("FAIL rst_drops_drdy got=%0d pulses exp=0", pulses);
        else n_pass++;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        n_chk++;
        if (drp_err !== 1'b0) $display("FAIL rst_clears_err got=%b exp=0", drp_err);
        else n_pass++;
        drp_xact(7'h40, 1'b0, 16'h0, 1'b0, lat, dout, exp);
        n_chk++;
        if (lat != LAT || dout !== 16'h0000)
            $display("FAIL rst_no_commit lat=%0d got=%h exp=0000", lat, dout);
        else n_pass++;
    endtask

    initial begin
        sample_a = 12'h0; sample_b = 12'h0;
        test_reset();
        test_conversion();
        test_cfg_rw();
        test_random();
        test_eoc_collision();
        test_back_to_back();
        test_reset_mid_write();
        wait_cyc(CONV + 4);
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/xadc_drp_responder.md
Name: xadc_drp_responder

Overview:
- Synthesizable stand-in for the XADC primitive: the responder end of the DRP read/write interface that the ADC controller initiates on.
- Runs a free-running two-channel conversion sequencer (aux 3, aux 11) and raises end-of-conversion pulses.
- Returns latched results over DRP with a fixed, parameterised read latency.
- Lets the ADC → BCD → display chain run on boards or benches without real analog inputs.

Parameters:
- CONV_CYCLES, 256: clk cycles between successive conversions; must be ≥ DRP_LATENCY+2.
- DRP_LATENCY, 4: cycles from den high to drdy high; legal range 1–15.
- ADDR_W, 7: DRP address width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- daddr  in  ADDR_W  DRP address, sampled when den=1.
- den  in  1  DRP enable, single-cycle strobe.
- dwe  in  1  DRP write enable, qualified by den.
- di  in  16  DRP write data.
- do_out  out  16  DRP read data, valid only while drdy=1.
- drdy  out  1  DRP ready, one-cycle pulse.
- eoc  out  1  end-of-conversion pulse, one cycle.
- channel  out  5  channel number of the last completed conversion.
- busy  out  1  high for the final 4 cycles before each eoc (conversion in progress).
- sample_a  in  12  unsigned value for aux channel 3.
- sample_b  in  12  unsigned value for aux channel 11.
- drp_err  out  1  sticky flag, set on protocol violation.

Behaviour:
- Reset values: do_out=0, drdy=0, eoc=0, channel=0, busy=0, drp_err=0, status registers=0, config registers=0, conversion counter=0, next channel=3.

Sequencer:
- Counter counts 0 .. CONV_CYCLES-1, then wraps to 0.
- On wrap: the selected sample is left-justified into its status register ({sample,4'b0}); ch3 → address 0x13, ch11 → address 0x1B.
- On the same cycle: eoc=1 and channel=3 or 11, then the selection toggles.
- First eoc is at cycle CONV_CYCLES after reset release; first channel reported is 3.

DRP FSM (IDLE, WAIT, RESP):
- IDLE: on den=1, capture daddr, dwe and di.
  - Read: snapshot the addressed register value on this same cycle.
  - Go to WAIT with latency count = DRP_LATENCY-1.
- WAIT: decrement each cycle; at 0 go to RESP. With DRP_LATENCY=1, go directly to RESP.
- RESP: drdy=1 for exactly one cycle, then return to IDLE.
  - Read: do_out = snapshot.
  - Write: do_out=0; write commits on this cycle.
- Total latency: drdy rises exactly DRP_LATENCY cycles after the den cycle.

Address map:
- 0x13, 0x1B: read-only status; writes are ignored without error.
- 0x40, 0x41, 0x42: config, read/write.
- All other addresses: read 0; writes discarded.

Boundary conditions:
- den=1 outside IDLE: request ignored, drp_err set sticky until reset, in-flight transaction unaffected.
- Conversion update on the same cycle as the read's den: the snapshot takes the pre-update value, because the register update lands on the next edge.
- Read of a status register updated during WAIT: returns the snapshot, not the new value.
- eoc and drdy on the same cycle: both assert; they are independent.
- rst_n low mid-transaction: transaction dropped immediately, drdy forced 0, no write commits.
- Sample inputs are assumed synchronous to clk; sampled only on the wrap cycle.

Optional Feature:
- Macro: XADC_RAMP_GEN_EN.
- Defined:
  - sample_a is replaced by an internal 12-bit up-counter that increments by 1 per ch3 conversion and wraps 0xFFF→0x000.
  - sample_b is replaced by the bitwise inverse of that counter.
  - The sample_a and sample_b ports remain but are unused.
- Undefined: the ports drive the conversions; no ramp logic is instantiated.

Decomposition:
- Shared package xadc_drp_pkg:
  - address constants ADDR_AUX3=7'h13, ADDR_AUX11=7'h1B, ADDR_CFG0/1/2=7'h40–42;
  - channel constants CH_AUX3=5'd3, CH_AUX11=5'd11;
  - DRP FSM state enum {IDLE, WAIT, RESP}.
- One sub-module: xadc_conv_sequencer. It owns the conversion counter, channel toggle, eoc/busy/channel outputs and the optional ramp. It delivers a write strobe, address and data for the status registers.
- The top holds the register file and the DRP FSM.

Test Plan:
- Reset release, CONV_CYCLES=256, sample_a=0xABC → eoc at cycle 256 with channel=3; read 0x13 → do_out=0xABC0, drdy exactly 4 cycles after den.
- Second conversion, sample_b=0x123 → eoc at cycle 512 with channel=11; read 0x1B → 0x1230.
- Write 0x5A5A to 0x41, then read 0x41 → 0x5A5A. Write 0xFFFF to 0x13 → next read still returns the last conversion value; drp_err=0.
- den pulsed again 2 cycles after a first den → single drdy only; drp_err=1 and held until rst_n low.
- den on the exact eoc cycle for 0x13 (old 0x0010, new sample 0x002) → returns 0x0010; the following read returns 0x0020.
- rst_n asserted during WAIT of a write to 0x40 → drdy never pulses; read after reset returns 0x0000. With XADC_RAMP_GEN_EN: 0x13 reads 0x0000, 0x0010, 0x0020 on successive ch3 conversions, and 0x1B reads 0xFFF0 after the first.
